// File: rtl/debug_trace_buf.sv
// debug_trace_buf: change-triggered trace capture of the SoC debug bus and LEDs.
// Each recorded entry is {timestamp, LED, DEBUG}. Entries are held in a
// show-ahead FIFO that drains over a valid/ready port. When an entry is lost
// because the FIFO is full, a sticky overflow flag and a saturating drop
// counter make the loss visible.
module debug_trace_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int TSW   = 16
) (
    input  logic           XCLK,
    input  logic           XRES,
    input  logic [127:0]   DEBUG,
    input  logic [3:0]     LED,
    input  logic           ARM,
    output logic           TVALID,
    input  logic           TREADY,
    output logic [127:0]   TDATA,
    output logic [3:0]     TLED,
    output logic [TSW-1:0] TSTAMP,
    output logic [AW:0]    COUNT,
    output logic           OVF,
    output logic [7:0]     DROPS,
    input  logic           CLR
);

    localparam int          SW       = 128 + 4;
    localparam int          EW       = SW + TSW;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    // Increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [TSW-1:0] timer;

    logic [SW-1:0]  smp_p1;
    logic [TSW-1:0] ts_p1;
    logic           vld_p1;

    logic [SW-1:0]  last_p2;
    logic           last_vld_p2;

    logic [EW-1:0]  mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           ovf;
    logic [7:0]     drops;

    logic           push_req;
    logic           pop;
    logic           full;
    logic           wr_en;
    logic           drop;
    logic [EW-1:0]  head;

    // Free-running timestamp counter, wraps naturally at 2^TSW.
    always_ff @(posedge XCLK) begin
        if (!XRES) timer <= '0;
        else       timer <= timer + TSW'(1);
    end

    // ---- stage 1: sample bus, LEDs and timestamp ----
    // Sample data path; no reset needed because vld_p1 qualifies it.
    always_ff @(posedge XCLK) begin
        smp_p1 <= {LED, DEBUG};
        ts_p1  <= timer;
    end

    // Sample valid follows ARM.
    always_ff @(posedge XCLK) begin
        if (!XRES) vld_p1 <= 1'b0;
        else       vld_p1 <= ARM;
    end

    // ---- stage 2: change detect and FIFO write ----
    // A push is requested for the first sample after arming or on any change.
    always_comb begin
        push_req = vld_p1 && (!last_vld_p2 || (smp_p1 != last_p2));
        pop      = TVALID && TREADY;
        full     = (count == FULL_CNT);
        // When full, a same-edge pop frees the slot the push needs.
        wr_en    = push_req && (!full || pop);
        drop     = push_req && full && !pop;
    end

    // Last-recorded value updates on every push request, even a dropped one.
    always_ff @(posedge XCLK) begin
        if (push_req) last_p2 <= smp_p1;
    end

    // Last-recorded valid: set on a push request, cleared while disarmed.
    always_ff @(posedge XCLK) begin
        if (!XRES)        last_vld_p2 <= 1'b0;
        else if (push_req) last_vld_p2 <= 1'b1;
        else if (!vld_p1)  last_vld_p2 <= 1'b0;
    end

    // Entry storage; the tail slot is written on an accepted push.
    always_ff @(posedge XCLK) begin
        if (wr_en) mem[wr_ptr] <= {ts_p1, smp_p1};
    end

    // Pointer and occupancy bookkeeping; occupancy resolves full versus empty.
    always_ff @(posedge XCLK) begin
        if (!XRES) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            if (wr_en && !pop)      count <= count + (AW+1)'(1);
            else if (!wr_en && pop) count <= count - (AW+1)'(1);
        end
    end

    // Overflow bookkeeping; a drop on the same edge as CLR still registers.
    always_ff @(posedge XCLK) begin
        if (!XRES) begin
            ovf   <= 1'b0;
            drops <= 8'd0;
        end else if (drop) begin
            ovf   <= 1'b1;
            drops <= CLR ? 8'd1 : sat_inc8(drops);
        end else if (CLR) begin
            ovf   <= 1'b0;
            drops <= 8'd0;
        end
    end

    // Show-ahead head outputs, forced to zero while empty.
    always_comb begin
        head   = mem[rd_ptr];
        TVALID = (count != '0);
        TDATA  = TVALID ? head[127:0]    : '0;
        TLED   = TVALID ? head[SW-1:128] : '0;
        TSTAMP = TVALID ? head[EW-1:SW]  : '0;
        COUNT  = count;
        OVF    = ovf;
        DROPS  = drops;
    end

endmodule

// File: tb/tb_debug_trace_buf.sv
// Directed testbench for debug_trace_buf with a scoreboard queue of expected
// trace entries.
module tb_debug_trace_buf;

    logic         XCLK;
    logic         XRES;
    logic [127:0] DEBUG;
    logic [3:0]   LED;
    logic         ARM;
    logic         TVALID;
    logic         TREADY;
    logic [127:0] TDATA;
    logic [3:0]   TLED;
    logic [15:0]  TSTAMP;
    logic [4:0]   COUNT;
    logic         OVF;
    logic [7:0]   DROPS;
    logic         CLR;

    int           vectors = 0;
    int           miscompares = 0;
    logic [147:0] exp_q[$];
    logic [15:0]  tb_time;

    debug_trace_buf #(.DEPTH(16), .AW(4), .TSW(16)) dut (
        .XCLK(XCLK), .XRES(XRES), .DEBUG(DEBUG), .LED(LED), .ARM(ARM),
        .TVALID(TVALID), .TREADY(TREADY), .TDATA(TDATA), .TLED(TLED),
        .TSTAMP(TSTAMP), .COUNT(COUNT), .OVF(OVF), .DROPS(DROPS), .CLR(CLR)
    );

    initial XCLK = 1'b0;
    always #5 XCLK = ~XCLK;

    // Bench-side timer: the value the DUT will timestamp on the next edge.
    always @(posedge XCLK) tb_time <= !XRES ? 16'd0 : tb_time + 16'd1;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] ts);
        exp_q.push_back({LED, DEBUG, ts});
    endtask

    // One clock; a pop happening on this edge is checked against the scoreboard.
    task automatic tick();
        if (TVALID && TREADY) begin
            vectors++;
            assert (exp_q.size() != 0) else begin
                miscompares++;
                $error("FAIL unexpected_entry observed=%0h expected=none", {TLED, TDATA, TSTAMP});
            end
            if (exp_q.size() != 0) chk("entry", 160'({TLED, TDATA, TSTAMP}), 160'(exp_q.pop_front()));
        end
        @(posedge XCLK);
        #1;
    endtask

    task automatic wait_time(input logic [15:0] t, input int budget);
        int n = 0;
        while (tb_time != t && n < budget) begin
            tick();
            n++;
        end
        chk("wait_timer", 160'(tb_time), 160'(t));
    endtask

    task automatic drain(input int budget);
        int n = 0;
        TREADY = 1'b1;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        TREADY = 1'b0;
        chk("drain_left", 160'(exp_q.size()), 160'(0));
        chk("drain_count", 160'(COUNT), 160'(0));
    endtask

    task automatic peek(input string tag);
        if (exp_q.size() == 0) chk({tag, "_nothing_expected"}, 160'(1), 160'(0));
        else chk(tag, 160'({TLED, TDATA, TSTAMP}), 160'(exp_q[0]));
    endtask

    initial begin
        XRES = 1'b0; ARM = 1'b0; TREADY = 1'b0; CLR = 1'b0;
        DEBUG = '0; LED = '0;
        repeat (3) tick();

        // Reset state
        chk("rst_tvalid", 160'(TVALID), 160'(0));
        chk("rst_count",  160'(COUNT),  160'(0));
        chk("rst_ovf",    160'(OVF),    160'(0));
        chk("rst_drops",  160'(DROPS),  160'(0));
        chk("rst_tdata",  160'(TDATA),  160'(0));
        chk("rst_tstamp", 160'(TSTAMP), 160'(0));

        // 1: constant bus -> exactly one first-after-arm entry
        XRES = 1'b1; ARM = 1'b1;
        push_exp(tb_time);
        tick();
        chk("t1_lat_early", 160'(TVALID), 160'(0));
        tick();
        chk("t1_lat_valid", 160'(TVALID), 160'(1));
        chk("t1_tdata",     160'(TDATA),  160'(0));
        repeat (50) tick();
        chk("t1_count", 160'(COUNT), 160'(1));
        drain(5);

        // 2: three changes at timer 10,11,12 with TREADY high
        XRES = 1'b0; tick(); XRES = 1'b1;
        TREADY = 1'b1;
        push_exp(tb_time);
        wait_time(16'd10, 50);
        DEBUG[31:0] = 32'd1; push_exp(tb_time);
        tick();
        chk("t2_lat_early", 160'(TVALID), 160'(0));
        DEBUG[31:0] = 32'd2; push_exp(tb_time);
        tick();
        chk("t2_lat_valid", 160'(TVALID), 160'(1));
        chk("t2_tstamp",    160'(TSTAMP), 160'(16'd10));
        DEBUG[31:0] = 32'd3; push_exp(tb_time);
        repeat (4) tick();
        chk("t2_all_out", 160'(exp_q.size()), 160'(0));
        chk("t2_count",   160'(COUNT),        160'(0));
        TREADY = 1'b0;

        // 3: 20 distinct values into a 16-deep FIFO
        for (int i = 0; i < 20; i++) begin
            DEBUG = {4{32'hA000_0000 + 32'(i)}};
            LED   = 4'(i);
            if (i < 16) push_exp(tb_time);
            tick();
        end
        repeat (2) tick();
        chk("t3_count", 160'(COUNT), 160'(16));
        chk("t3_ovf",   160'(OVF),   160'(1));
        chk("t3_drops", 160'(DROPS), 160'(4));
        peek("t3_head");

        // 4: full, push and pop on the same edge -> no drop
        DEBUG = {4{32'hB000_0001}}; LED = 4'h5;
        push_exp(tb_time);
        tick();
        TREADY = 1'b1;
        tick();
        TREADY = 1'b0;
        chk("t4_count", 160'(COUNT), 160'(16));
        chk("t4_drops", 160'(DROPS), 160'(4));
        chk("t4_ovf",   160'(OVF),   160'(1));
        peek("t4_head_hold");
        tick();
        peek("t4_head_stable");
        drain(40);
        CLR = 1'b1; tick(); CLR = 1'b0;
        chk("t3_clr_ovf",   160'(OVF),   160'(0));
        chk("t3_clr_drops", 160'(DROPS), 160'(0));

        // CLR coinciding with a drop: the drop wins
        LED = 4'h0;
        for (int i = 0; i < 17; i++) begin
            DEBUG = {4{32'hC000_0000 + 32'(i)}};
            if (i < 16) push_exp(tb_time);
            tick();
        end
        CLR = 1'b1; tick(); CLR = 1'b0;
        chk("clrdrop_ovf",   160'(OVF),   160'(1));
        chk("clrdrop_drops", 160'(DROPS), 160'(1));
        chk("clrdrop_count", 160'(COUNT), 160'(16));

        // 5: reset with 7 entries held
        TREADY = 1'b1;
        repeat (9) tick();
        TREADY = 1'b0;
        chk("t5_count7", 160'(COUNT), 160'(7));
        XRES = 1'b0; tick(); XRES = 1'b1;
        chk("t5_count",  160'(COUNT),  160'(0));
        chk("t5_tvalid", 160'(TVALID), 160'(0));
        chk("t5_ovf",    160'(OVF),    160'(0));
        chk("t5_drops",  160'(DROPS),  160'(0));
        chk("t5_tdata",  160'(TDATA),  160'(0));
        exp_q.delete();
        push_exp(16'h0000);
        repeat (2) tick();
        chk("t5_first_count", 160'(COUNT),  160'(1));
        chk("t5_first_ts",    160'(TSTAMP), 160'(0));
        peek("t5_first_head");
        drain(5);

        // 6: timestamp wrap
        wait_time(16'hFFFF, 70000);
        DEBUG = {4{32'hD000_0001}}; push_exp(tb_time);
        tick();
        DEBUG = {4{32'hD000_0002}}; push_exp(tb_time);
        repeat (2) tick();
        chk("t6_count", 160'(COUNT),  160'(2));
        chk("t6_ts_hi", 160'(TSTAMP), 160'(16'hFFFF));
        drain(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/debug_trace_buf.md
Name: debug_trace_buf

Overview:
- Trace-capture stage directly downstream of the SoC's DEBUG[3:0][31:0] and LED outputs.
- Registers the debug bus every cycle and records a timestamped entry whenever the sampled value differs from the last recorded one.
- Entries go into a show-ahead FIFO that a host-side drain (bench monitor or UART dumper) empties over a valid/ready port.
- Overflow is sticky and dropped entries are counted, so lost trace is always detectable.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- AW, 4, log2(DEPTH).
- TSW, 16, timestamp width in bits.

Ports:
- XCLK  in  1  core clock; all logic on the rising edge.
- XRES  in  1  synchronous reset, active-low; sampled on the XCLK rising edge.
- DEBUG  in  128  SoC debug bus, packed as {DEBUG[3],DEBUG[2],DEBUG[1],DEBUG[0]}.
- LED  in  4  SoC LED outputs; captured alongside DEBUG and included in the change compare.
- ARM  in  1  level; capture enabled while high.
- TVALID  out  1  FIFO non-empty.
- TREADY  in  1  consumer accepts the head entry when TVALID&TREADY.
- TDATA  out  128  head entry debug value.
- TLED  out  4  head entry LED value.
- TSTAMP  out  TSW  head entry timestamp.
- COUNT  out  AW+1  current occupancy, 0..DEPTH.
- OVF  out  1  sticky; set when an entry is dropped because the FIFO is full.
- DROPS  out  8  count of dropped entries; saturates at 255.
- CLR  in  1  single-cycle pulse; clears OVF and DROPS only.

Behaviour:
- Reset (XRES=0 at an edge):
  - FIFO pointers = 0, COUNT=0, TVALID=0, OVF=0, DROPS=0, timer=0.
  - Sample stage invalid, last-recorded value invalid.
  - TDATA, TLED and TSTAMP are 0 while empty.
  - Reset mid-operation discards all entries with no partial pop/push.
- Timer: free-running TSW-bit counter, increments every non-reset cycle, wraps from 2^TSW-1 to 0.
- Stage 1 (edge k): register {LED,DEBUG} into smp, timer value into smp_ts, ARM into smp_v.
- Stage 2 (edge k+1): push request when smp_v=1 and (last invalid or smp != last).
  - On a push request, last <= smp and last becomes valid, whether or not the entry fits.
- Latency: a DEBUG change applied before edge k is visible with TVALID=1 after edge k+1, i.e. 2 cycles. TSTAMP equals the timer value sampled at edge k.
- ARM low: smp_v=0, no pushes, last is invalidated. The first sample after re-arm is always recorded, even if unchanged.
- Pop occurs when TVALID&TREADY at an edge; the head advances.
  - TDATA, TLED and TSTAMP are combinational from the head entry.
  - They must hold stable while TVALID=1 and TREADY=0.
- Push with COUNT<DEPTH: entry written at the tail; COUNT+1.
- Push with COUNT=DEPTH and no pop in the same cycle: entry dropped, OVF<=1, DROPS+1 (saturating), FIFO contents unchanged.
- Simultaneous push and pop:
  - Both take effect; COUNT unchanged.
  - When full, the push is accepted (no drop) because a slot frees the same edge.
  - When COUNT=1, the popped entry is the old head; the new entry becomes head next cycle with TVALID remaining 1.
- Pop when empty: ignored (TVALID=0 implies no pop).
- CLR and a drop in the same cycle: the drop wins. OVF=1 and DROPS=1 after the edge.
- Pointers are AW bits and wrap modulo DEPTH. Full/empty is distinguished by COUNT, not by pointer equality.

Test Plan:
1. Reset, then ARM=1 with DEBUG constant 0x0 -> exactly one entry (first-after-arm), TDATA=0. No further entries over 50 cycles; COUNT=1.
2. ARM=1, TREADY=1; DEBUG[0] takes 1,2,3 on consecutive cycles starting at timer=10 -> three entries in order with TSTAMP 10,11,12. Each TVALID appears 2 cycles after its change.
3. TREADY=0; 20 distinct DEBUG values on successive cycles with DEPTH=16 -> COUNT=16, OVF=1, DROPS=4. Draining then yields the first 16 values in order; CLR pulse -> OVF=0, DROPS=0.
4. FIFO full, TREADY=1 and a new change in the same cycle -> no drop, COUNT stays 16, DROPS unchanged.
5. XRES=0 for one cycle with COUNT=7 and ARM=1 -> next cycle COUNT=0, TVALID=0, OVF=0, timer restarts at 0. First post-reset sample is recorded.
6. Timer wrap: change DEBUG at timer=0xFFFF and at the next cycle -> TSTAMP 0xFFFF then 0x0000, both entries present.
